// File: rtl/led_pattern_driver_pkg.sv
// Shared types and constants for the LED pattern driver.
//   mode_t       : display mode encoding (matches the 2-bit mode output)
//   *_INIT       : pattern state loaded when a mode is entered
//   next_mode    : mode advance order, wrapping BREATHE back to BINARY
//   init_pattern : pattern state to load for a given mode
package led_pkg;

  localparam int unsigned PAT_W     = 4;
  localparam int unsigned PWM_IDX_W = 4;

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_SHIFT   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic [PAT_W-1:0] BINARY_INIT  = 4'b0000;
  localparam logic [PAT_W-1:0] SHIFT_INIT   = 4'b0001;
  localparam logic [PAT_W-1:0] BLINK_INIT   = 4'b1111;
  localparam logic [PAT_W-1:0] BREATHE_INIT = 4'b0000;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_BINARY:  return MODE_SHIFT;
      MODE_SHIFT:   return MODE_BLINK;
      MODE_BLINK:   return MODE_BREATHE;
      default:      return MODE_BINARY;
    endcase
  endfunction

  function automatic logic [PAT_W-1:0] init_pattern(input mode_t m);
    case (m)
      MODE_BINARY:  return BINARY_INIT;
      MODE_SHIFT:   return SHIFT_INIT;
      MODE_BLINK:   return BLINK_INIT;
      default:      return BREATHE_INIT;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_driver_if.sv
// Board-side signal bundle of the LED pattern driver.
//   mode_next : level from the upstream debouncer (rising edge advances mode)
//   led1..4   : LED drives, led1 = pattern[3] ... led4 = pattern[0]
//   mode      : current display mode
// master = the board/upstream side, slave = the driver.
interface led_pattern_driver_if;
  logic       mode_next;
  logic       led1;
  logic       led2;
  logic       led3;
  logic       led4;
  logic [1:0] mode;

  modport master (
    output mode_next,
    input  led1, led2, led3, led4, mode
  );

  modport slave (
    input  mode_next,
    output led1, led2, led3, led4, mode
  );
endinterface

// File: rtl/led_pattern_driver_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clock, reset : system clock, synchronous active-high reset
//   i_clear      : restart the count from 0 at the next edge
//   o_tick_c     : combinational, high while the count sits at DIV-1
// DIV = 1 yields a tick on every cycle.
module tick_gen #(
  parameter int unsigned DIV = 4,
  parameter int unsigned W   = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == LAST);

  // Count 0..DIV-1 and wrap; clear and reset both force 0.
  always_ff @(posedge clock) begin
    if (reset || i_clear || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Animated four-LED output stage with four selectable display modes.
//   clock, reset : 100 MHz system clock, synchronous active-high reset
//   bus (slave)  : mode_next in; led1..led4 and mode out (all registered)
// STEP_DIV sets the pattern step period, PWM_DIV the length of one PWM slot
// (16 slots per PWM frame, used only by BREATHE).
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int unsigned STEP_DIV = 12_500_000,
  parameter int unsigned PWM_DIV  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  led_pattern_driver_if.slave  bus
);

  localparam int unsigned STEP_W = $clog2(STEP_DIV);
  localparam int unsigned SLOT_W = $clog2(PWM_DIV) + 1;

  mode_t                r_mode;
  mode_t                w_mode_nxt;
  logic [PAT_W-1:0]     r_pat;
  logic [PAT_W-1:0]     w_pat_nxt;
  logic                 r_dir;        // 0: up (toward LED1 / rising duty), 1: down
  logic                 w_dir_nxt;
  logic [PAT_W-1:0]     w_pattern;
  logic                 r_mn_q;
  logic [PWM_IDX_W-1:0] r_pwm_idx;
  logic [PAT_W-1:0]     r_led;
  logic [1:0]           r_mode_out;
  logic                 w_rise;
  logic                 w_step_tick;
  logic                 w_slot_tick;

  assign w_rise = bus.mode_next & ~r_mn_q;

  // Step prescaler restarts on every mode change so a new mode gets a full step.
  tick_gen #(.DIV(STEP_DIV), .W(STEP_W)) u_step_tick (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_rise),
    .o_tick_c (w_step_tick)
  );

  tick_gen #(.DIV(PWM_DIV), .W(SLOT_W)) u_slot_tick (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (1'b0),
    .o_tick_c (w_slot_tick)
  );

  // Mode/pattern state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode <= MODE_BINARY;
      r_pat  <= BINARY_INIT;
      r_dir  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_pat  <= w_pat_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  // Next state and display pattern; a mode change beats a coincident step.
  always_comb begin
    w_mode_nxt = r_mode;
    w_pat_nxt  = r_pat;
    w_dir_nxt  = r_dir;
    w_pattern  = r_pat;

    if (r_mode == MODE_BREATHE) begin
      w_pattern = {PAT_W{r_pwm_idx < r_pat}};
    end

    if (w_rise) begin
      w_mode_nxt = next_mode(r_mode);
      w_pat_nxt  = init_pattern(next_mode(r_mode));
      w_dir_nxt  = 1'b0;
    end else if (w_step_tick) begin
      case (r_mode)
        MODE_BINARY: begin
          w_pat_nxt = r_pat + 4'd1;
        end
        MODE_SHIFT: begin
          // Bounce the lit bit between LED4 and LED1.
          if (!r_dir) begin
            if (r_pat[3]) begin
              w_pat_nxt = r_pat >> 1;
              w_dir_nxt = 1'b1;
            end else begin
              w_pat_nxt = r_pat << 1;
            end
          end else begin
            if (r_pat[0]) begin
              w_pat_nxt = r_pat << 1;
              w_dir_nxt = 1'b0;
            end else begin
              w_pat_nxt = r_pat >> 1;
            end
          end
        end
        MODE_BLINK: begin
          w_pat_nxt = ~r_pat;
        end
        default: begin
          // Duty ramps 0..15..0; each end value is visited once per sweep.
          if (!r_dir) begin
            if (r_pat == 4'd15) begin
              w_pat_nxt = 4'd14;
              w_dir_nxt = 1'b1;
            end else begin
              w_pat_nxt = r_pat + 4'd1;
            end
          end else begin
            if (r_pat == 4'd0) begin
              w_pat_nxt = 4'd1;
              w_dir_nxt = 1'b0;
            end else begin
              w_pat_nxt = r_pat - 4'd1;
            end
          end
        end
      endcase
    end
  end

  // Edge detector, PWM slot index and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mn_q     <= 1'b0;
      r_pwm_idx  <= '0;
      r_led      <= '0;
      r_mode_out <= 2'd0;
    end else begin
      r_mn_q     <= bus.mode_next;
      if (w_slot_tick) begin
        r_pwm_idx <= r_pwm_idx + 4'd1;
      end
      r_led      <= w_pattern;
      r_mode_out <= r_mode;
    end
  end

  assign bus.led1 = r_led[3];
  assign bus.led2 = r_led[2];
  assign bus.led3 = r_led[1];
  assign bus.led4 = r_led[0];
  assign bus.mode = r_mode_out;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: a fast instance (STEP_DIV=4, PWM_DIV=1)
// checked every cycle against a step-count model, plus a slow instance
// (STEP_DIV=64) used to observe whole PWM frames at a fixed duty.
module tb_led_pattern_driver;

  localparam int STEP_DIV = 4;
  localparam int PWM_DIV  = 1;
  localparam int SLOW_DIV = 64;

  logic clock;
  logic reset;

  led_pattern_driver_if bus ();
  led_pattern_driver_if bus_slow ();

  led_pattern_driver #(.STEP_DIV(STEP_DIV), .PWM_DIV(PWM_DIV)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  led_pattern_driver #(.STEP_DIV(SLOW_DIV), .PWM_DIV(PWM_DIV)) u_dut_slow (
    .clock (clock),
    .reset (reset),
    .bus   (bus_slow)
  );

  logic [3:0] w_leds;
  logic [3:0] w_slow_leds;
  assign w_leds      = {bus.led1, bus.led2, bus.led3, bus.led4};
  assign w_slow_leds = {bus_slow.led1, bus_slow.led2, bus_slow.led3, bus_slow.led4};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode, steps taken since the mode was entered, prescaler
  // phase, PWM index and the previous mode_next level.
  int         m_mode, m_steps, m_presc, m_pwm;
  logic       m_mnq;
  logic [3:0] exp_led;
  logic [1:0] exp_mode;

  logic [3:0] shift_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0010};

  function automatic logic [3:0] model_pat(input int md, input int n, input int pwm);
    int pos;
    int duty;
    case (md)
      0: return 4'(n % 16);
      1: begin
        pos = n % 6;
        if (pos > 3) pos = 6 - pos;
        return 4'(1 << pos);
      end
      2: return ((n % 2) == 0) ? 4'hF : 4'h0;
      default: begin
        duty = n % 30;
        if (duty > 15) duty = 30 - duty;
        return (pwm < duty) ? 4'hF : 4'h0;
      end
    endcase
  endfunction

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic cyc(input logic mn, input logic rst);
    logic rise;
    logic tick;
    bus.mode_next      = mn;
    bus_slow.mode_next = mn;
    reset              = rst;
    @(posedge clock);
    if (rst) begin
      exp_led = 4'h0; exp_mode = 2'd0;
      m_mode = 0; m_steps = 0; m_presc = 0; m_pwm = 0; m_mnq = 1'b0;
    end else begin
      exp_led  = model_pat(m_mode, m_steps, m_pwm);
      exp_mode = 2'(m_mode);
      rise = mn && !m_mnq;
      tick = (m_presc == STEP_DIV - 1);
      if (rise) begin
        m_mode  = (m_mode + 1) % 4;
        m_steps = 0;
        m_presc = 0;
      end else begin
        if (tick) m_steps++;
        m_presc = (m_presc + 1) % STEP_DIV;
      end
      m_pwm = (m_pwm + 1) % 16;
      m_mnq = mn;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    n_cmp++;
    if ({bus.mode, w_leds} !== 6'b0) begin
      n_err++;
      $display("FAIL reset: got mode=%0d leds=%b, want mode=0 leds=0000", bus.mode, w_leds);
    end
    n_cmp++;
    if ({bus_slow.mode, w_slow_leds} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_slow: got mode=%0d leds=%b, want mode=0 leds=0000", bus_slow.mode, w_slow_leds);
    end
  endtask

  task automatic test_binary();
    logic [3:0] want;
    for (int k = 1; k <= 70; k++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if ({bus.mode, w_leds} !== {exp_mode, exp_led}) begin
        n_err++;
        $display("FAIL binary_model k=%0d: got mode=%0d leds=%b, want mode=%0d leds=%b",
                 k, bus.mode, w_leds, exp_mode, exp_led);
      end
      if (k == 4 || k == 5 || k == 61 || k == 65) begin
        want = (k == 5) ? 4'b0001 : (k == 61) ? 4'b1111 : 4'b0000;
        n_cmp++;
        if (w_leds !== want) begin
          n_err++;
          $display("FAIL binary_step k=%0d: got leds=%b, want %b", k, w_leds, want);
        end
      end
    end
  endtask

  task automatic test_shift();
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 29; k++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if ({bus.mode, w_leds} !== {exp_mode, exp_led}) begin
        n_err++;
        $display("FAIL shift_model k=%0d: got mode=%0d leds=%b, want mode=%0d leds=%b",
                 k, bus.mode, w_leds, exp_mode, exp_led);
      end
      if ((k % 4) == 1) begin
        n_cmp++;
        if ({bus.mode, w_leds} !== {2'd1, shift_seq[(k - 1) / 4]}) begin
          n_err++;
          $display("FAIL shift_seq k=%0d: got mode=%0d leds=%b, want mode=1 leds=%b",
                   k, bus.mode, w_leds, shift_seq[(k - 1) / 4]);
        end
      end
    end
  endtask

  task automatic test_blink_hold();
    logic [3:0] want;
    for (int k = 0; k <= 27; k++) begin
      cyc(k < 20, 1'b0);
      n_cmp++;
      if ({bus.mode, w_leds} !== {exp_mode, exp_led}) begin
        n_err++;
        $display("FAIL blink_model k=%0d: got mode=%0d leds=%b, want mode=%0d leds=%b",
                 k, bus.mode, w_leds, exp_mode, exp_led);
      end
      if (k >= 1) begin
        want = ((((k - 1) / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
        n_cmp++;
        if ({bus.mode, w_leds} !== {2'd2, want}) begin
          n_err++;
          $display("FAIL blink_hold k=%0d: got mode=%0d leds=%b, want mode=2 leds=%b",
                   k, bus.mode, w_leds, want);
        end
      end
    end
  endtask

  task automatic test_breathe();
    int hi [4];
    for (int i = 0; i < 4; i++) hi[i] = 0;
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 330; k++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if ({bus.mode, w_leds} !== {exp_mode, exp_led}) begin
        n_err++;
        $display("FAIL breathe_model k=%0d: got mode=%0d leds=%b, want mode=%0d leds=%b",
                 k, bus.mode, w_leds, exp_mode, exp_led);
      end
      if (k <= SLOW_DIV) begin
        n_cmp++;
        if ({bus_slow.mode, w_slow_leds} !== {2'd3, 4'b0000}) begin
          n_err++;
          $display("FAIL breathe_duty0 k=%0d: got mode=%0d leds=%b, want mode=3 leds=0000",
                   k, bus_slow.mode, w_slow_leds);
        end
      end
      if (k >= 260 && k <= 275) begin
        for (int i = 0; i < 4; i++) hi[i] += int'(w_slow_leds[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hi[i] != 4) begin
        n_err++;
        $display("FAIL breathe_duty4 led_bit%0d: got %0d high cycles per frame, want 4", i, hi[i]);
      end
    end
  endtask

  task automatic test_collision();
    int budget;
    budget = 0;
    while (m_presc != STEP_DIV - 1 && budget < 20) begin
      cyc(1'b0, 1'b0);
      budget++;
    end
    n_cmp++;
    if (m_presc != STEP_DIV - 1 || m_mode != 3) begin
      n_err++;
      $display("FAIL collision_setup: got presc=%0d mode=%0d, want presc=%0d mode=3",
               m_presc, m_mode, STEP_DIV - 1);
    end
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if ({bus.mode, w_leds} !== {exp_mode, exp_led}) begin
        n_err++;
        $display("FAIL collision_model k=%0d: got mode=%0d leds=%b, want mode=%0d leds=%b",
                 k, bus.mode, w_leds, exp_mode, exp_led);
      end
      n_cmp++;
      if ({bus.mode, w_leds} !== {2'd0, (k >= 5) ? 4'b0001 : 4'b0000}) begin
        n_err++;
        $display("FAIL collision k=%0d: got mode=%0d leds=%b, want mode=0 leds=%b",
                 k, bus.mode, w_leds, (k >= 5) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    cyc(1'b1, 1'b0);
    budget = 0;
    while (m_steps != 2 && budget < 20) begin
      cyc(1'b0, 1'b0);
      budget++;
    end
    n_cmp++;
    if (m_steps != 2 || m_mode != 1) begin
      n_err++;
      $display("FAIL reset_mid_setup: got steps=%0d mode=%0d, want steps=2 mode=1", m_steps, m_mode);
    end
    cyc(1'b0, 1'b1);
    n_cmp++;
    if ({bus.mode, w_leds} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid: got mode=%0d leds=%b, want mode=0 leds=0000", bus.mode, w_leds);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (w_leds !== ((k == 5) ? 4'b0001 : 4'b0000)) begin
        n_err++;
        $display("FAIL reset_mid_restart k=%0d: got leds=%b, want %b",
                 k, w_leds, (k == 5) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    logic mn;
    logic rst;
    mn = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 11) == 0) mn = ~mn;
      rst = ($urandom_range(0, 149) == 0);
      cyc(mn, rst);
      n_cmp++;
      if ({bus.mode, w_leds} !== {exp_mode, exp_led}) begin
        n_err++;
        $display("FAIL random k=%0d: got mode=%0d leds=%b, want mode=%0d leds=%b",
                 k, bus.mode, w_leds, exp_mode, exp_led);
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.mode_next      = 1'b0;
    bus_slow.mode_next = 1'b0;
    test_reset();
    test_binary();
    test_shift();
    test_blink_hold();
    test_breathe();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
